risc_control_unit: RTL

- Control stage directly upstream of the single-cycle datapath.
- Consumes the fetched instruction (datapath mem_instr_out) and the datapath's pre-flags (Pre_C/V/Z/N).
- Drives every datapath control strobe.
- Owns the LOAD/RUN/HALT sequencing, the architectural status-flag register (C,V,Z,N) and branch-condition evaluation.

---
 rtl/risc_ctrl_pkg.sv | 67 ++++++
 rtl/risc_cond_eval.sv | 28 ++
 rtl/risc_control_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/risc_ctrl_pkg.sv
// rtl/risc_ctrl_pkg.sv - Shared types, opcodes, condition codes and field positions for the RISC control unit.
package risc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int OP_MSB   = 15;
    localparam int COND_MSB = 10;
    localparam int COND_LSB = 8;
    localparam int FN_MSB   = 1;
    localparam int FN_LSB   = 0;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_LHI  = 5'b00001;
    localparam logic [4:0] OP_LLI  = 5'b00010;
    localparam logic [4:0] OP_LDR  = 5'b00011;
    localparam logic [4:0] OP_STR  = 5'b00101;
    localparam logic [4:0] OP_ADDI = 5'b00111;
    localparam logic [4:0] OP_SUBI = 5'b01000;
    localparam logic [4:0] OP_JMP  = 5'b10000;
    localparam logic [4:0] OP_JR   = 5'b10001;
    localparam logic [4:0] OP_BCC  = 5'b11000;
    localparam logic [4:0] OP_OUTR = 5'b11100;
    localparam logic [4:0] OP_HLT  = 5'b11111;

    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_ADC = 2'b01;
    localparam logic [1:0] FN_SUB = 2'b10;
    localparam logic [1:0] FN_SBB = 2'b11;

    localparam logic [2:0] COND_EQ = 3'b000;
    localparam logic [2:0] COND_NE = 3'b001;
    localparam logic [2:0] COND_CS = 3'b010;
    localparam logic [2:0] COND_CC = 3'b011;
    localparam logic [2:0] COND_MI = 3'b100;
    localparam logic [2:0] COND_PL = 3'b101;
    localparam logic [2:0] COND_VS = 3'b110;
    localparam logic [2:0] COND_AL = 3'b111;

    typedef struct packed {
        logic rf_we;
        logic dwe;
        logic src_read_b;
        logic src_alu_b;
        logic adc;
        logic sub;
        logic sbb;
        logic jmp;
        logic branch;
        logic label_pc;
        logic rm_pc;
        logic rd_pc;
        logic mem_rf;
        logic alu_rf;
        logic rm_rf;
        logic pc_rf;
        logic lhi;
        logic lli;
        logic outr;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/risc_cond_eval.sv
// rtl/risc_cond_eval.sv - Combinational branch-condition evaluation from latched status flags.
module risc_cond_eval
    import risc_ctrl_pkg::*;
(
    input  logic       i_c,
    input  logic       i_v,
    input  logic       i_z,
    input  logic       i_n,
    input  logic [2:0] i_cond,
    output logic       o_take
);

    always_comb begin
        o_take = 1'b0;
        case (i_cond)
            COND_EQ: o_take = i_z;
            COND_NE: o_take = ~i_z;
            COND_CS: o_take = i_c;
            COND_CC: o_take = ~i_c;
            COND_MI: o_take = i_n;
            COND_PL: o_take = ~i_n;
            COND_VS: o_take = i_v;
            COND_AL: o_take = 1'b1;
            default: o_take = 1'b0;
        endcase
    end

endmodule

// File: rtl/risc_control_unit.sv
// rtl/risc_control_unit.sv - LOAD/RUN/HALT sequencer, decode and status flags; RISC_CTRL_INSTR_COUNT_EN adds the retired counter.
module risc_control_unit
    import risc_ctrl_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int CNTW = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        load_req,
    input  logic [15:0] instr,
    input  logic        Pre_C,
    input  logic        Pre_V,
    input  logic        Pre_Z,
    input  logic        Pre_N,
    output logic        test_normal,
    output logic        flag_HLT,
    output logic        RF_write_en,
    output logic        data_write_en,
    output logic        Src_Read_B,
    output logic        Src_ALU_B,
    output logic        ADC,
    output logic        SUB,
    output logic        SBB,
    output logic        JMP,
    output logic        BRANCH,
    output logic        flag_label_PC,
    output logic        flag_Rm_PC,
    output logic        flag_Rd_PC,
    output logic        flag_mem_RF,
    output logic        flag_ALU_RF,
    output logic        flag_Rm_RF,
    output logic        flag_PC_RF,
    output logic        LHI,
    output logic        LLI,
    output logic        flag_OutR,
    output logic        C,
    output logic        V,
    output logic        Z,
    output logic        N,
`ifdef RISC_CTRL_INSTR_COUNT_EN
    output logic [CNTW-1:0] retired,
`endif
    output logic        halted,
    output logic        illegal
);

    state_t           r_state;
    logic             r_c, r_v, r_z, r_n;
    logic             r_illegal;

    logic [OPW-1:0]   w_op;
    logic [1:0]       w_fn;
    logic             w_run;
    logic             w_take;
    logic             w_legal;
    logic             w_hlt;
    logic             w_flag_upd;
    ctrl_t            w_dec;
    ctrl_t            w_ctrl;
    logic             w_unused_fields;

    assign w_op            = instr[OP_MSB -: OPW];
    assign w_fn            = instr[FN_MSB:FN_LSB];
    assign w_run           = (r_state == ST_RUN);
    assign w_unused_fields = ^instr[7:2];

    // Branches see the flags latched by earlier instructions, never this cycle's Pre_*.
    risc_cond_eval u_cond_eval (
        .i_c    (r_c),
        .i_v    (r_v),
        .i_z    (r_z),
        .i_n    (r_n),
        .i_cond (instr[COND_MSB:COND_LSB]),
        .o_take (w_take)
    );

    always_comb begin
        w_dec      = CTRL_NONE;
        w_legal    = 1'b1;
        w_hlt      = 1'b0;
        w_flag_upd = 1'b0;
        case (w_op)
            OP_ALU: begin
                w_dec.rf_we  = 1'b1;
                w_dec.alu_rf = 1'b1;
                w_dec.adc    = (w_fn == FN_ADC);
                w_dec.sub    = (w_fn == FN_SUB);
                w_dec.sbb    = (w_fn == FN_SBB);
                w_flag_upd   = 1'b1;
            end
            OP_LHI: begin
                w_dec.lhi        = 1'b1;
                w_dec.src_read_b = 1'b1;
                w_dec.rf_we      = 1'b1;
            end
            OP_LLI: begin
                w_dec.lli   = 1'b1;
                w_dec.rf_we = 1'b1;
            end
            OP_LDR: begin
                w_dec.src_alu_b = 1'b1;
                w_dec.mem_rf    = 1'b1;
                w_dec.rf_we     = 1'b1;
            end
            OP_STR: begin
                w_dec.src_alu_b  = 1'b1;
                w_dec.src_read_b = 1'b1;
                w_dec.dwe        = 1'b1;
            end
            OP_ADDI: begin
                w_dec.src_alu_b = 1'b1;
                w_dec.alu_rf    = 1'b1;
                w_dec.rf_we     = 1'b1;
                w_flag_upd      = 1'b1;
            end
            OP_SUBI: begin
                w_dec.sub       = 1'b1;
                w_dec.src_alu_b = 1'b1;
                w_dec.alu_rf    = 1'b1;
                w_dec.rf_we     = 1'b1;
                w_flag_upd      = 1'b1;
            end
            OP_JMP: begin
                w_dec.jmp      = 1'b1;
                w_dec.label_pc = 1'b1;
            end
            OP_JR: begin
                w_dec.jmp   = 1'b1;
                w_dec.rm_pc = 1'b1;
            end
            OP_BCC: begin
                w_dec.branch   = w_take;
                w_dec.label_pc = w_take;
            end
            OP_OUTR: w_dec.outr = 1'b1;
            OP_HLT:  w_hlt      = 1'b1;
            default: w_legal    = 1'b0;
        endcase
    end

    // Gating on the registered state lets an asynchronous clr kill every strobe at once.
    assign w_ctrl = (w_run && w_legal && !w_hlt) ? w_dec : CTRL_NONE;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= ST_LOAD;
            r_c       <= 1'b0;
            r_v       <= 1'b0;
            r_z       <= 1'b0;
            r_n       <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (w_run && w_flag_upd) begin
                {r_c, r_v, r_z, r_n} <= {Pre_C, Pre_V, Pre_Z, Pre_N};
            end
            if (load_req) begin
                r_state   <= ST_LOAD;
                r_illegal <= 1'b0;
            end else begin
                case (r_state)
                    ST_LOAD: if (start) r_state <= ST_RUN;
                    ST_RUN: begin
                        if (w_hlt) begin
                            r_state <= ST_HALT;
                        end else if (!w_legal) begin
                            r_state   <= ST_HALT;
                            r_illegal <= 1'b1;
                        end
                    end
                    ST_HALT: if (start) r_state <= ST_RUN;
                    default: r_state <= ST_LOAD;
                endcase
            end
        end
    end

`ifdef RISC_CTRL_INSTR_COUNT_EN
    logic [CNTW-1:0] r_retired;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_retired <= '0;
        end else if (load_req) begin
            r_retired <= '0;
        end else if (w_run && w_legal && !w_hlt) begin
            r_retired <= r_retired + CNTW'(1);
        end
    end

    assign retired = r_retired;
`else
    localparam int unused_cntw = CNTW;
`endif

    assign test_normal   = (r_state == ST_LOAD);
    assign halted        = (r_state == ST_HALT);
    assign flag_HLT      = w_run && w_legal && !w_hlt;
    assign illegal       = r_illegal;
    assign {C, V, Z, N}  = {r_c, r_v, r_z, r_n};

    assign RF_write_en   = w_ctrl.rf_we;
    assign data_write_en = w_ctrl.dwe;
    assign Src_Read_B    = w_ctrl.src_read_b;
    assign Src_ALU_B     = w_ctrl.src_alu_b;
    assign ADC           = w_ctrl.adc;
    assign SUB           = w_ctrl.sub;
    assign SBB           = w_ctrl.sbb;
    assign JMP           = w_ctrl.jmp;
    assign BRANCH        = w_ctrl.branch;
    assign flag_label_PC = w_ctrl.label_pc;
    assign flag_Rm_PC    = w_ctrl.rm_pc;
    assign flag_Rd_PC    = w_ctrl.rd_pc;
    assign flag_mem_RF   = w_ctrl.mem_rf;
    assign flag_ALU_RF   = w_ctrl.alu_rf;
    assign flag_Rm_RF    = w_ctrl.rm_rf;
    assign flag_PC_RF    = w_ctrl.pc_rf;
    assign LHI           = w_ctrl.lhi;
    assign LLI           = w_ctrl.lli;
    assign flag_OutR     = w_ctrl.outr;

endmodule
